// File: rtl/mdu_pkg.sv
// Shared definitions for the RV32M multiply/divide sequencer: funct3/funct7 codes and FSM states.
package mdu_pkg;

  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StDiv,
    StFixup,
    StDone
  } mdu_state_e;

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-divide step: shift the next dividend bit into the partial remainder and
// subtract the divisor if it fits.
module mdu_divstep #(
  parameter int unsigned DWIDTH = 32
) (
  input  logic [DWIDTH-1:0] rem_i,
  input  logic              bit_i,
  input  logic [DWIDTH-1:0] divisor_i,
  output logic [DWIDTH-1:0] rem_o,
  output logic              q_o
);

  logic [DWIDTH:0] partial;
  logic [DWIDTH:0] diff;
  logic            take;

  // rem_i < divisor_i always holds, so diff[DWIDTH] is a clean borrow flag.
  always_comb begin
    partial = {rem_i, bit_i};
    diff    = partial - {1'b0, divisor_i};
    take    = ~diff[DWIDTH];
    q_o     = take;
    rem_o   = take ? diff[DWIDTH-1:0] : partial[DWIDTH-1:0];
  end

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative RV32M multiply/divide unit (shift-add multiplier, restoring divider).
// Optional MDU_EARLY_OUT_EN: leave MUL as soon as the remaining multiplier bits are zero.
module mdu_sequencer
  import mdu_pkg::*;
#(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned CNTW   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [2:0]        funct3_i,
  input  logic [DWIDTH-1:0] rs1_i,
  input  logic [DWIDTH-1:0] rs2_i,
  input  logic              flush_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [DWIDTH-1:0] res_o,
  output logic              busy_o
);

  localparam int unsigned       PW     = 2 * DWIDTH;
  localparam logic [DWIDTH-1:0] MinNeg = {1'b1, {(DWIDTH-1){1'b0}}};

  mdu_state_e        state_q, state_d;
  logic [CNTW-1:0]   cnt_q, cnt_d;
  logic [2:0]        f3_q, f3_d;
  logic              neg_q, neg_d;
  logic [DWIDTH-1:0] opnd_q, opnd_d;  // multiplicand or divisor magnitude
  logic [PW-1:0]     acc_q, acc_d;    // {hi, lo}: product, or {remainder, dividend/quotient}
  logic [DWIDTH-1:0] res_q, res_d;
  logic              resp_valid_q, resp_valid_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;

  logic              sgn1, sgn2, neg1, neg2, is_ovf;
  logic [DWIDTH-1:0] mag1, mag2;
  logic [DWIDTH:0]   mul_sum;
  logic [PW-1:0]     mul_next, div_next, prod_al, prod_fx;
  logic [DWIDTH-1:0] div_rem, div_sel, fix_res;
  logic              div_qbit, mul_done;

  always_comb begin
    sgn1 = (funct3_i == F3_MULH) || (funct3_i == F3_MULHSU) ||
           (funct3_i == F3_DIV)  || (funct3_i == F3_REM);
    sgn2 = (funct3_i == F3_MULH) || (funct3_i == F3_DIV) || (funct3_i == F3_REM);
    neg1 = sgn1 & rs1_i[DWIDTH-1];
    neg2 = sgn2 & rs2_i[DWIDTH-1];
    mag1 = neg1 ? -rs1_i : rs1_i;
    mag2 = neg2 ? -rs2_i : rs2_i;
    is_ovf = funct3_i[2] && sgn2 && (rs1_i == MinNeg) && (rs2_i == '1);
  end

  mdu_divstep #(
    .DWIDTH(DWIDTH)
  ) u_divstep (
    .rem_i    (acc_q[PW-1:DWIDTH]),
    .bit_i    (acc_q[DWIDTH-1]),
    .divisor_i(opnd_q),
    .rem_o    (div_rem),
    .q_o      (div_qbit)
  );

  always_comb begin
    mul_sum  = {1'b0, acc_q[PW-1:DWIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[DWIDTH-1:1]};
    div_next = {div_rem, acc_q[DWIDTH-2:0], div_qbit};
`ifdef MDU_EARLY_OUT_EN
    // Low cnt_q bits of mul_next are the multiplier bits still to be consumed.
    mul_done = (cnt_q == '0) || ((mul_next & ((PW'(1) << cnt_q) - PW'(1))) == '0);
`else
    mul_done = (cnt_q == '0);
`endif
  end

  // cnt_q holds the skipped step count on an early exit, zero otherwise.
  always_comb begin
    prod_al = acc_q >> cnt_q;
    prod_fx = neg_q ? -prod_al : prod_al;
    div_sel = f3_q[1] ? acc_q[PW-1:DWIDTH] : acc_q[DWIDTH-1:0];
    if (f3_q[2]) begin
      fix_res = neg_q ? -div_sel : div_sel;
    end else begin
      fix_res = (f3_q == F3_MUL) ? prod_fx[DWIDTH-1:0] : prod_fx[PW-1:DWIDTH];
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    f3_d         = f3_q;
    neg_d        = neg_q;
    opnd_d       = opnd_q;
    acc_d        = acc_q;
    res_d        = res_q;
    resp_valid_d = resp_valid_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i && req_ready_q) begin
          f3_d  = funct3_i;
          neg_d = (funct3_i[2] && funct3_i[1]) ? neg1 : (neg1 ^ neg2);
          cnt_d = CNTW'(DWIDTH - 1);
          if (!funct3_i[2]) begin
            state_d = StMul;
            acc_d   = {{DWIDTH{1'b0}}, mag2};
            opnd_d  = mag1;
          end else if (rs2_i == '0) begin
            state_d      = StDone;
            res_d        = funct3_i[1] ? rs1_i : '1;
            resp_valid_d = 1'b1;
          end else if (is_ovf) begin
            state_d      = StDone;
            res_d        = funct3_i[1] ? '0 : MinNeg;
            resp_valid_d = 1'b1;
          end else begin
            state_d = StDiv;
            acc_d   = {{DWIDTH{1'b0}}, mag1};
            opnd_d  = mag2;
          end
        end
      end
      StMul: begin
        acc_d = mul_next;
        if (mul_done) state_d = StFixup;
        else          cnt_d   = cnt_q - CNTW'(1);
      end
      StDiv: begin
        acc_d = div_next;
        if (cnt_q == '0) state_d = StFixup;
        else             cnt_d   = cnt_q - CNTW'(1);
      end
      StFixup: begin
        res_d        = fix_res;
        cnt_d        = '0;
        state_d      = StDone;
        resp_valid_d = 1'b1;
      end
      StDone: begin
        if (resp_ready_i) begin
          state_d      = StIdle;
          resp_valid_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
    if (flush_i) begin
      state_d      = StIdle;
      resp_valid_d = 1'b0;
    end
    req_ready_d = (state_d == StIdle);
    busy_d      = (state_d != StIdle);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      f3_q         <= '0;
      neg_q        <= 1'b0;
      opnd_q       <= '0;
      acc_q        <= '0;
      res_q        <= '0;
      resp_valid_q <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      f3_q         <= f3_d;
      neg_q        <= neg_d;
      opnd_q       <= opnd_d;
      acc_q        <= acc_d;
      res_q        <= res_d;
      resp_valid_q <= resp_valid_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign res_o        = res_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: directed RV32M cases, backpressure, flush, reset,
// then random operations checked against a plain-arithmetic reference model.
module tb_mdu_sequencer;
  import mdu_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req_valid_i = 1'b0;
  logic         flush_i = 1'b0;
  logic         resp_ready_i = 1'b1;
  logic [2:0]   funct3_i = '0;
  logic [W-1:0] rs1_i = '0;
  logic [W-1:0] rs2_i = '0;
  logic         req_ready_o, resp_valid_o, busy_o;
  logic [W-1:0] res_o;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  bit rand_bp = 1'b0;

  typedef struct {
    logic [W-1:0] res;
    int           lat;
    int           acc;
    string        name;
  } exp_t;
  exp_t sb[$];

  mdu_sequencer #(.DWIDTH(W), .CNTW(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .funct3_i    (funct3_i),
    .rs1_i       (rs1_i),
    .rs2_i       (rs2_i),
    .flush_i     (flush_i),
    .resp_valid_o(resp_valid_o),
    .resp_ready_i(resp_ready_i),
    .res_o       (res_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
    end
  endtask

  // Reference: RV32M semantics from 64-bit integer arithmetic.
  function automatic logic [W-1:0] ref_res(input logic [2:0] f3, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    longint          sa = longint'($signed(a));
    longint          sb_ = longint'($signed(b));
    longint unsigned ua = {32'b0, a};
    longint unsigned ub = {32'b0, b};
    logic [63:0]     p;
    case (f3)
      F3_MUL:    begin p = ua * ub;  return p[31:0];  end
      F3_MULH:   begin p = sa * sb_; return p[63:32]; end
      F3_MULHSU: begin p = sa * longint'(ub); return p[63:32]; end
      F3_MULHU:  begin p = ua * ub;  return p[63:32]; end
      F3_DIV: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = sa / sb_;
        return p[31:0];
      end
      F3_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
      F3_REM: begin
        if (b == 0) return a;
        p = sa % sb_;
        return p[31:0];
      end
      default:   return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    if (f3[2] && (b == 0)) return 0;
    if ((f3 == F3_DIV || f3 == F3_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
    return W + 1;
  endfunction

  // Monitor: pops one expectation per presented response, checks hold during backpressure.
  logic         prev_valid = 1'b0;
  logic [W-1:0] held = '0;
  exp_t         mon_e;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else if (resp_valid_o) begin
      if (!prev_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_resp: got res 0x%0h, want no response", res_o);
        end else begin
          mon_e = sb.pop_front();
          check({mon_e.name, "_res"}, res_o, mon_e.res);
          check({mon_e.name, "_lat"}, cyc - mon_e.acc, mon_e.lat);
        end
        held = res_o;
      end else begin
        check("hold_res", res_o, held);
      end
      prev_valid = !resp_ready_i;
    end else begin
      prev_valid = 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      resp_ready_i = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic issue(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit chk, input logic [W-1:0] want, input string name);
    exp_t e;
    int   n = 0;
    @(negedge clk);
    while (!req_ready_o && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready_o) begin
      check({name, "_ready_timeout"}, req_ready_o, 1);
      return;
    end
    req_valid_i = 1'b1;
    funct3_i    = f3;
    rs1_i       = a;
    rs2_i       = b;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    if (chk) begin
      e.res  = want;
      e.lat  = ref_lat(f3, a, b);
      e.acc  = cyc;
      e.name = name;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() > 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end of test, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int           n;
    logic [2:0]   f3;
    logic [W-1:0] a, b;
    $display("mdu_sequencer bench start, funct7 %b", F7_MULDIV);

    @(negedge clk);
    check("rst_req_ready", req_ready_o, 1);
    check("rst_resp_valid", resp_valid_o, 0);
    check("rst_res", res_o, 0);
    check("rst_busy", busy_o, 0);
    rst_n = 1'b1;

    issue(F3_MUL, 32'd7, 32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, "mul_7xm3");
    @(negedge clk);
    check("busy_in_mul", busy_o, 1);
    check("not_ready_in_mul", req_ready_o, 0);
    issue(F3_MULH, 32'h8000_0000, 32'h8000_0000, 1, 32'h4000_0000, "mulh_min");
    issue(F3_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFE, "mulhu_max");
    issue(F3_MULHSU, 32'hFFFF_FFFF, 32'd2, 1, 32'hFFFF_FFFF, "mulhsu_m1x2");
    issue(F3_DIV, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFD, "div_m7_2");
    issue(F3_REM, 32'hFFFF_FFF9, 32'd2, 1, 32'hFFFF_FFFF, "rem_m7_2");
    issue(F3_DIVU, 32'd100, 32'd7, 1, 32'd14, "divu_100_7");
    issue(F3_REMU, 32'd100, 32'd7, 1, 32'd2, "remu_100_7");
    issue(F3_DIV, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, "div_by0");
    issue(F3_REM, 32'd5, 32'd0, 1, 32'd5, "rem_by0");
    issue(F3_DIVU, 32'd9, 32'd0, 1, 32'hFFFF_FFFF, "divu_by0");
    issue(F3_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, "div_ovf");
    issue(F3_REM, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'd0, "rem_ovf");
    drain();

    // Backpressure in DONE.
    resp_ready_i = 1'b0;
    issue(F3_DIVU, 32'd100, 32'd7, 1, 32'd14, "divu_bp");
    n = 0;
    while (!resp_valid_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("bp_seen", resp_valid_o, 1);
    repeat (5) begin
      @(negedge clk);
      check("bp_valid", resp_valid_o, 1);
      check("bp_res", res_o, 32'd14);
    end
    @(posedge clk);
    #1;
    resp_ready_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("bp_valid_drop", resp_valid_o, 0);
    check("bp_ready_back", req_ready_o, 1);

    // Flush on cycle 10 of a divide.
    issue(F3_DIV, 32'd1000, 32'd7, 0, '0, "div_flush");
    repeat (9) @(posedge clk);
    #1;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    @(negedge clk);
    check("flush_busy", busy_o, 0);
    check("flush_ready", req_ready_o, 1);
    check("flush_valid", resp_valid_o, 0);
    repeat (40) @(negedge clk);
    issue(F3_MUL, 32'd3, 32'd4, 1, 32'd12, "mul_3x4");
    drain();

    // Flush beats a simultaneous accept.
    @(negedge clk);
    req_valid_i = 1'b1;
    flush_i     = 1'b1;
    funct3_i    = F3_MUL;
    rs1_i       = 32'd2;
    rs2_i       = 32'd2;
    @(negedge clk);
    req_valid_i = 1'b0;
    flush_i     = 1'b0;
    check("flush_acc_busy", busy_o, 0);
    check("flush_acc_ready", req_ready_o, 1);
    repeat (40) @(negedge clk);

    // Reset mid-multiply.
    issue(F3_MUL, 32'd5, 32'd6, 0, '0, "mul_rst");
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_req_ready", req_ready_o, 1);
    check("midrst_resp_valid", resp_valid_o, 0);
    check("midrst_res", res_o, 0);
    check("midrst_busy", busy_o, 0);
    rst_n = 1'b1;

    // Random operations with random backpressure.
    rand_bp = 1'b1;
    for (int i = 0; i < 60; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom();
      b  = $urandom();
      case ($urandom_range(0, 7))
        0: b = '0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'd1;
        3: a = 32'h8000_0000;
        default: ;
      endcase
      issue(f3, a, b, 1, ref_res(f3, a, b), $sformatf("rnd%0d_f%0d", i, f3));
    end
    drain();
    rand_bp = 1'b0;
    @(negedge clk);
    resp_ready_i = 1'b1;
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
